scroll_display_ctrl: RTL

SCROLL_DISPLAY_CTRL -- requirements
Module: scroll_display_ctrl

---
 rtl/scroll_pkg.sv | 24 ++
 rtl/btn_edge.sv | 28 ++
 rtl/scroll_display_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// Shared constants for the scrolling 7-segment display: active-low segment
// codes (bit order g..a) and the progress-bar lit-count rule.
package scroll_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Character codes, active-low, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_H = 7'h09;
  localparam logic [6:0] SEG_I = 7'h79;
  localparam logic [6:0] SEG_L = 7'h47;
  localparam logic [6:0] SEG_P = 7'h0C;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Number of lit bar segments: full bar just after wrap, shrinking as pos grows.
  function automatic int bar_lit(input int pos_v, input int pos_max, input int bar_w);
    if (pos_v == 0) begin
      return 0;
    end
    return bar_w - (pos_v * bar_w) / (pos_max + 1);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button followed by a rising-edge detector.
// The pulse is combinational from the flops, so a consumer register toggles on the third edge.
module btn_edge (
  input  logic clock,
  input  logic reset_1,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling message on a multiplexed 7-segment display with run/pause and
// direction buttons, a writable message buffer and a thermometer progress bar.
module scroll_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int MSG_LEN    = 40,
  parameter int SCROLL_DIV = 50_000_000,
  parameter int SCAN_DIV   = 25_000,
  parameter int BAR_W      = 8
) (
  input  logic                                          clock,
  input  logic                                          reset_1,
  input  logic                                          btn_run,
  input  logic                                          btn_dir,
  input  logic                                          wr_en,
  input  logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] wr_addr,
  input  logic [6:0]                                    wr_data,
  output logic [6:0]                                    seg,
  output logic [DIGITS-1:0]                             an,
  output logic [BAR_W-1:0]                              bar,
  output logic [$clog2(MSG_LEN+DIGITS+1)-1:0]           pos,
  output logic                                          running,
  output logic                                          dir_up
);

  import scroll_pkg::*;

  localparam int POS_MAX = MSG_LEN + DIGITS;
  localparam int PW = $clog2(MSG_LEN + DIGITS + 1);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic run_rise;
  logic dir_rise;

  logic             running_q;
  logic             dir_up_q;
  logic [PW-1:0]    pos_q, pos_d;
  logic [SW-1:0]    scroll_cnt_q, scroll_cnt_d;
  logic             scroll_tick;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  logic             scan_tc;
  logic [DW-1:0]    digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [BAR_W-1:0] bar_q, bar_d;

  logic [6:0]       msg_q [MSG_LEN];
  int               rel;
  logic             visible;
  logic [AW-1:0]    rd_addr;
  int               bar_lit_n;

  btn_edge u_run_edge (
    .clock   (clock),
    .reset_1 (reset_1),
    .btn_i   (btn_run),
    .rise_o  (run_rise)
  );

  btn_edge u_dir_edge (
    .clock   (clock),
    .reset_1 (reset_1),
    .btn_i   (btn_dir),
    .rise_o  (dir_rise)
  );

  // Scroll prescaler is held at zero while paused so a resume always waits a full period.
  assign scroll_tick = running_q && (scroll_cnt_q == SW'(SCROLL_DIV - 1));

  always_comb begin
    scroll_cnt_d = scroll_cnt_q + SW'(1);
    if (!running_q || scroll_tick) begin
      scroll_cnt_d = '0;
    end
  end

  always_comb begin
    pos_d = pos_q;
    if (scroll_tick) begin
      if (dir_up_q) begin
        pos_d = (pos_q == PW'(POS_MAX)) ? '0 : pos_q + PW'(1);
      end else begin
        pos_d = (pos_q == '0) ? PW'(POS_MAX) : pos_q - PW'(1);
      end
    end
  end

  assign scan_tc = (scan_cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    digit_d    = digit_q;
    if (scan_tc) begin
      scan_cnt_d = '0;
      digit_d    = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
    end
  end

  // Digit k at frame pos shows character pos-1-k; frames outside the message are blank.
  always_comb begin
    rel     = int'(pos_q) - int'(digit_q);
    visible = (rel >= 1) && (rel <= MSG_LEN);
    rd_addr = visible ? AW'(rel - 1) : '0;
    seg_d   = visible ? msg_q[rd_addr] : SEG_BLANK;
    an_d    = ~(DIGITS'(1) << digit_q);
  end

  assign bar_lit_n = bar_lit(int'(pos_q), POS_MAX, BAR_W);

  for (genvar gi = 0; gi < BAR_W; gi++) begin : g_bar
    assign bar_d[gi] = (gi < bar_lit_n);
  end

  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) begin
      running_q    <= 1'b0;
      dir_up_q     <= 1'b1;
      pos_q        <= '0;
      scroll_cnt_q <= '0;
      scan_cnt_q   <= '0;
      digit_q      <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      bar_q        <= '0;
    end else begin
      if (run_rise) begin
        running_q <= ~running_q;
      end
      if (dir_rise) begin
        dir_up_q <= ~dir_up_q;
      end
      pos_q        <= pos_d;
      scroll_cnt_q <= scroll_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      bar_q        <= bar_d;
    end
  end

  // Message buffer is deliberately not reset; out-of-range addresses are dropped.
  always_ff @(posedge clock) begin
    if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bar     = bar_q;
  assign pos     = pos_q;
  assign running = running_q;
  assign dir_up  = dir_up_q;

endmodule
